fir_tap_sched: RTL and testbench

Sequencing controller for the team's 3-tap FIR path. It owns the sample delay line and the coefficient bank, and time-multiplexes one multiply-accumulate unit over the taps, one product per cycle. It sits between the sample source and the downstream consumer. It keeps the existing start/stop/done run control and adds valid/ready handshakes on both the sample and result sides.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_mac.sv | 42 ++++
 rtl/fir_tap_sched.sv | 170 +++++++++++++++++
 tb/tb_fir_tap_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared types and constants for the 3-tap FIR sequencing path.
//   DATAWIDTH : sample / coefficient width (signed Q8.8)
//   NTAPS     : number of taps
//   FRAC      : fractional bits of samples and coefficients
//   ACCW      : accumulator / result width (signed Q16.16)
//   AW        : coefficient address width
//   COEF_ONE  : 1.0 in Q8.8, the reset value of every coefficient
//   state_t   : sequencing FSM states
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int DATAWIDTH = 16;
   localparam int NTAPS     = 3;
   localparam int FRAC      = 8;
   localparam int ACCW      = 2 * DATAWIDTH;
   localparam int AW        = (NTAPS > 1) ? $clog2(NTAPS) : 1;

   localparam logic [DATAWIDTH-1:0] COEF_ONE = DATAWIDTH'(1 << FRAC);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      MAC  = 2'd2,
      OUT  = 2'd3
   } state_t;

endpackage

// File: rtl/fir_mac.sv
// -----------------------------------------------------------------------------
// fir_mac
// Single signed multiply-accumulate unit shared across all taps.
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset, clears the accumulator
//   clr  in   clears the accumulator (start of a new sample)
//   en   in   accumulate a*b this cycle
//   a    in   signed coefficient operand
//   b    in   signed sample operand
//   sum  out  acc + a*b, i.e. the value the accumulator takes when en=1
// The full-width product is added with plain two's-complement wrap-around.
// -----------------------------------------------------------------------------
module fir_mac #(
   parameter int DW = 16,
   parameter int W  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [W-1:0]  sum
);

   logic signed [W-1:0]    acc;
   logic signed [2*DW-1:0] prod;

   assign prod = a * b;
   assign sum  = acc + W'(prod);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/fir_tap_sched.sv
// -----------------------------------------------------------------------------
// fir_tap_sched
// Sequencing controller for the 3-tap FIR path. Owns the sample delay line
// and the coefficient bank and time-multiplexes one MAC over the taps, one
// product per cycle.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   level, requests a run (ignored while stop=1)
//   stop       in   level, ends a run at the next safe point
//   s_valid    in   input sample valid
//   s_ready    out  registered; high only in WAIT
//   s_data     in   signed Q8.8 sample x[n]
//   coef_we    in   coefficient write strobe (honoured only in IDLE)
//   coef_addr  in   tap index k (k >= NTAPS ignored)
//   coef_data  in   signed Q8.8 coefficient h[k]
//   m_valid    out  registered; high only in OUT
//   m_ready    in   result consumer ready
//   m_data     out  signed Q16.16 y[n], stable while m_valid && !m_ready
//   busy       out  high whenever state != IDLE
//   done       out  one-cycle pulse on return to IDLE from a run
//   dbg_state  out  current FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits on ready, and both s_ready and m_valid are
// registered so there is no combinational path from s_valid or m_ready.
// -----------------------------------------------------------------------------
module fir_tap_sched
   import fir_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DATAWIDTH-1:0] s_data,
   input  logic                 coef_we,
   input  logic [AW-1:0]        coef_addr,
   input  logic [DATAWIDTH-1:0] coef_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [ACCW-1:0]      m_data,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           dbg_state
);

   state_t                state;
   logic [AW-1:0]         k;
   logic [DATAWIDTH-1:0]  d [NTAPS];
   logic [DATAWIDTH-1:0]  h [NTAPS];

   logic                  mac_clr;
   logic                  mac_en;
   logic [DATAWIDTH-1:0]  tap_h;
   logic [DATAWIDTH-1:0]  tap_d;
   logic signed [ACCW-1:0] mac_sum;

   assign dbg_state = state;

   // The accumulator is cleared on the same edge the sample is taken, so the
   // first MAC cycle starts from zero.
   assign mac_clr = (state == WAIT) && !stop && s_valid && s_ready;
   assign mac_en  = (state == MAC);

   always_comb begin
      tap_h = '0;
      tap_d = '0;
      if (int'(k) < NTAPS) begin
         tap_h = h[k];
         tap_d = d[k];
      end
   end

   fir_mac #(
      .DW (DATAWIDTH),
      .W  (ACCW)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (tap_h),
      .b   (tap_d),
      .sum (mac_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         k       <= '0;
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            d[i] <= '0;
            h[i] <= COEF_ONE;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (coef_we && (int'(coef_addr) < NTAPS)) begin
                  h[coef_addr] <= coef_data;
               end
               if (start && !stop) begin
                  state   <= WAIT;
                  s_ready <= 1'b1;
                  busy    <= 1'b1;
                  for (int i = 0; i < NTAPS; i++) begin
                     d[i] <= '0;
                  end
               end
            end

            WAIT: begin
               // stop wins over a sample offered in the same cycle
               if (stop) begin
                  state   <= IDLE;
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else if (s_valid && s_ready) begin
                  d[0] <= s_data;
                  for (int i = NTAPS - 1; i > 0; i--) begin
                     d[i] <= d[i-1];
                  end
                  k       <= '0;
                  s_ready <= 1'b0;
                  state   <= MAC;
               end
            end

            MAC: begin
               if (k == AW'(NTAPS - 1)) begin
                  // mac_sum already includes the last product
                  m_data  <= mac_sum;
                  m_valid <= 1'b1;
                  state   <= OUT;
               end else begin
                  k <= k + 1'b1;
               end
            end

            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (stop) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state   <= WAIT;
                     s_ready <= 1'b1;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               m_valid <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tap_sched.sv
// -----------------------------------------------------------------------------
// tb_fir_tap_sched
// Directed bench for fir_tap_sched: a table of samples with hand-computed
// Q16.16 results, plus hand-written sequences for back-pressure, stop,
// busy-time coefficient writes, start/stop conflict and mid-run reset.
// -----------------------------------------------------------------------------
module tb_fir_tap_sched;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam int         LAT     = 4;   // edges from accept to m_valid sampled high

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop;
   logic        s_valid, s_ready;
   logic [15:0] s_data;
   logic        coef_we;
   logic [1:0]  coef_addr;
   logic [15:0] coef_data;
   logic        m_valid, m_ready;
   logic [31:0] m_data;
   logic        busy, done;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   fir_tap_sched dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic write_coef(input logic [1:0] a, input logic [15:0] v);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = v;
      tick();
      coef_we   = 1'b0;
   endtask

   task automatic start_run(input string nm);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({nm, " busy"}, 32'(busy), 32'd1);
      check({nm, " s_ready"}, 32'(s_ready), 32'd1);
   endtask

   task automatic stop_in_wait(input string nm);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check({nm, " done"}, 32'(done), 32'd1);
      check({nm, " busy"}, 32'(busy), 32'd0);
      check({nm, " state"}, 32'(dbg_state), 32'(ST_IDLE));
      tick();
      check({nm, " done once"}, 32'(done), 32'd0);
   endtask

   // Offer one sample, check latency and result. With hs=1 the result is
   // consumed; with hs=0 the task returns while the result is pending.
   task automatic run_sample(input logic [15:0] x, input logic [31:0] exp,
                             input bit hs, input string nm);
      int n;
      n = 0;
      while (!s_ready && n < 20) begin
         tick();
         n++;
      end
      check({nm, " s_ready"}, 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = x;
      tick();
      s_valid = 1'b0;
      check({nm, " s_ready low after accept"}, 32'(s_ready), 32'd0);
      n = 0;
      while (!m_valid && n < 20) begin
         tick();
         n++;
      end
      check({nm, " m_valid"}, 32'(m_valid), 32'd1);
      check({nm, " latency"}, 32'(n + 1), 32'(LAT));
      check({nm, " m_data"}, m_data, exp);
      if (hs) begin
         m_ready = 1'b1;
         tick();
         m_ready = 1'b0;
         check({nm, " m_valid cleared"}, 32'(m_valid), 32'd0);
      end
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [15:0] x;
      logic [31:0] y;
   } vec_t;

   vec_t tbl [5];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      // default h = 1.0 on all taps, so y = 0x100 * (d0 + d1 + d2)
      tbl[0] = '{16'h0080, 32'h0000_8000};
      tbl[1] = '{16'h0080, 32'h0001_0000};
      tbl[2] = '{16'h0080, 32'h0001_8000};
      tbl[3] = '{16'hFF00, 32'h0000_0000};  // -1.0 + 0.5 + 0.5
      tbl[4] = '{16'h8000, 32'hFF7F_8000};  // -128.0 - 1.0 + 0.5

      rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0; m_ready = 1'b0;
      repeat (3) tick();
      check("reset s_ready", 32'(s_ready), 32'd0);
      check("reset m_valid", 32'(m_valid), 32'd0);
      check("reset m_data", m_data, 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      tick();

      // default coefficients, table-driven stream
      start_run("run1 start");
      for (int i = 0; i < 5; i++) begin
         run_sample(tbl[i].x, tbl[i].y, 1'b1, $sformatf("vec%0d", i));
      end
      stop_in_wait("run1 stop");

      // custom coefficients; new run clears the delay line
      write_coef(2'd0, 16'h0080);
      write_coef(2'd1, 16'h0040);
      write_coef(2'd2, 16'h0020);
      write_coef(2'd3, 16'h7FFF);  // out of range, ignored
      start_run("run2 start");
      run_sample(16'h0066, 32'h0000_3300, 1'b1, "h2 s0");
      run_sample(16'h0066, 32'h0000_4C80, 1'b1, "h2 s1");

      // write attempts while busy are ignored: 0x3300+0x1980+0x0CC0
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'h7FFF;
      run_sample(16'h0066, 32'h0000_5940, 1'b1, "busy we");
      coef_we = 1'b0;

      // back-pressure: d = {0, 0x66, 0x66} -> 0x1980 + 0x0CC0
      run_sample(16'h0000, 32'h0000_2640, 1'b0, "hold");
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("hold%0d m_valid", i), 32'(m_valid), 32'd1);
         check($sformatf("hold%0d m_data", i), m_data, 32'h0000_2640);
         check($sformatf("hold%0d s_ready", i), 32'(s_ready), 32'd0);
         check($sformatf("hold%0d done", i), 32'(done), 32'd0);
      end
      stop = 1'b1; m_ready = 1'b1;
      tick();
      stop = 1'b0; m_ready = 1'b0;
      check("out stop done", 32'(done), 32'd1);
      check("out stop busy", 32'(busy), 32'd0);
      check("out stop m_valid", 32'(m_valid), 32'd0);
      check("out stop state", 32'(dbg_state), 32'(ST_IDLE));
      tick();
      check("out stop done once", 32'(done), 32'd0);

      // restore 1.0, start together with stop stays idle
      for (int i = 0; i < 3; i++) write_coef(2'(i), 16'h0100);
      start = 1'b1; stop = 1'b1;
      tick();
      tick();
      start = 1'b0; stop = 1'b0;
      check("start+stop state", 32'(dbg_state), 32'(ST_IDLE));
      check("start+stop busy", 32'(busy), 32'd0);
      start_run("run3 start");
      run_sample(16'h009A, 32'h0000_9A00, 1'b1, "cleared");
      check("run3 state wait", 32'(dbg_state), 32'(ST_WAIT));
      stop_in_wait("run3 stop");

      // reset during MAC discards the sample and restores h = 1.0
      write_coef(2'd0, 16'h0200);
      start_run("run4 start");
      s_valid = 1'b1; s_data = 16'h0010;
      tick();
      s_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid rst state", 32'(dbg_state), 32'(ST_IDLE));
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst s_ready", 32'(s_ready), 32'd0);
      check("mid rst m_valid", 32'(m_valid), 32'd0);
      check("mid rst m_data", m_data, 32'd0);
      check("mid rst done", 32'(done), 32'd0);
      tick();
      check("post rst done", 32'(done), 32'd0);
      start_run("run5 start");
      run_sample(16'h0010, 32'h0000_1000, 1'b1, "h reset");
      stop_in_wait("run5 stop");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
